// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT
  } fetch_state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC arithmetic: sequential +4 or branch target, with alignment flag.
module pc_next
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk_unused_n,
  input  logic        [DATA_WIDTH-1:0] pc,
  input  logic signed [DATA_WIDTH-1:0] imm,
  input  logic                         pcsrc,
  output logic        [DATA_WIDTH-1:0] next_pc,
  output logic                         misaligned
);

  logic        [DATA_WIDTH-1:0] seq_pc;
  logic signed [DATA_WIDTH-1:0] tgt_pc;
  logic                         unused_ok;

  // Both sums wrap modulo 2^DATA_WIDTH; a negative imm is a backward branch.
  always_comb begin
    seq_pc     = pc + DATA_WIDTH'(INSTR_BYTES);
    tgt_pc     = $signed(pc) + imm;
    next_pc    = pcsrc ? DATA_WIDTH'($unsigned(tgt_pc)) : seq_pc;
    misaligned = |next_pc[1:0];
    unused_ok  = clk_unused_n;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time,
// holds the returned instruction for decode and follows branch decisions.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  PCSrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  output logic                  misalign
);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  next_misaligned;

  // The next PC is always derived from the held instruction's address.
  pc_next #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pc_next (
    .clk_unused_n(1'b1),
    .pc          (instr_pc),
    .imm         (ImmOp),
    .pcsrc       (PCSrc),
    .next_pc     (next_pc),
    .misaligned  (next_misaligned)
  );

  // The request address is the registered PC, so it stays stable while REQ stalls.
  assign imem_req_addr = pc;

  // Fetch FSM; every output is set here so nothing is combinational from inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      imem_req_valid <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
      instr_valid    <= 1'b0;
      misalign       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state          <= REQ;
          imem_req_valid <= 1'b1;
        end
        REQ: begin
          if (imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state       <= HOLD;
            instr       <= imem_rsp_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (next_misaligned) begin
              state    <= HALT;
              misalign <= 1'b1;
            end else begin
              state          <= REQ;
              pc             <= next_pc;
              imem_req_valid <= 1'b1;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule
